// File: rtl/inv_subs_layer.sv
// inv_subs_layer: iterative inverse 4-bit S-box layer over a SIZE-bit state word.
// NPC nibbles are substituted per clock, so one word takes STEPS = SIZE/(4*NPC) cycles.
// The work register is rotated left by 4*NPC bits on every step. After STEPS steps
// every nibble is back in its original position.
// Optional macro INV_SUBS_FWD_EN adds a `fwd` input. When the value latched at accept
// is 1, the forward S-box is used, so the same block can serve encryption.
`timescale 1ns/1ps

module inv_subs_layer #(
    parameter int SIZE = 64,
    parameter int NPC  = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef INV_SUBS_FWD_EN
    input  logic            fwd,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            busy
);

    localparam int SW    = 4 * NPC;
    localparam int STEPS = SIZE / SW;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] work;
    logic [SIZE-1:0] step_next;
    logic [2*SIZE-1:0] dbl;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
`ifdef INV_SUBS_FWD_EN
    logic            fwd_q;
`endif

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        case (n)
            4'h0: inv_sbox = 4'h5;
            4'h1: inv_sbox = 4'hE;
            4'h2: inv_sbox = 4'hF;
            4'h3: inv_sbox = 4'h8;
            4'h4: inv_sbox = 4'hC;
            4'h5: inv_sbox = 4'h1;
            4'h6: inv_sbox = 4'h2;
            4'h7: inv_sbox = 4'hD;
            4'h8: inv_sbox = 4'hB;
            4'h9: inv_sbox = 4'h4;
            4'hA: inv_sbox = 4'h6;
            4'hB: inv_sbox = 4'h3;
            4'hC: inv_sbox = 4'h0;
            4'hD: inv_sbox = 4'h7;
            4'hE: inv_sbox = 4'h9;
            default: inv_sbox = 4'hA;
        endcase
    endfunction

`ifdef INV_SUBS_FWD_EN
    function automatic logic [3:0] fwd_sbox(input logic [3:0] n);
        case (n)
            4'h0: fwd_sbox = 4'hC;
            4'h1: fwd_sbox = 4'h5;
            4'h2: fwd_sbox = 4'h6;
            4'h3: fwd_sbox = 4'hB;
            4'h4: fwd_sbox = 4'h9;
            4'h5: fwd_sbox = 4'h0;
            4'h6: fwd_sbox = 4'hA;
            4'h7: fwd_sbox = 4'hD;
            4'h8: fwd_sbox = 4'h3;
            4'h9: fwd_sbox = 4'hE;
            4'hA: fwd_sbox = 4'hF;
            4'hB: fwd_sbox = 4'h8;
            4'hC: fwd_sbox = 4'h4;
            4'hD: fwd_sbox = 4'h7;
            4'hE: fwd_sbox = 4'h1;
            default: fwd_sbox = 4'h2;
        endcase
    endfunction
`endif

    // Rotate left by SW bits via a doubled word so that NPC*4 == SIZE needs no special case,
    // then substitute the nibbles that have just wrapped into the low SW bits.
    always_comb begin
        dbl       = {work, work};
        step_next = dbl[2*SIZE-1-SW -: SIZE];
        for (int j = 0; j < NPC; j++) begin
`ifdef INV_SUBS_FWD_EN
            step_next[4*j +: 4] = fwd_q ? fwd_sbox(step_next[4*j +: 4])
                                        : inv_sbox(step_next[4*j +: 4]);
`else
            step_next[4*j +: 4] = inv_sbox(step_next[4*j +: 4]);
`endif
        end
    end

    // Control FSM and work register. The handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            work        <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef INV_SUBS_FWD_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        work       <= in_data;
                        cnt        <= '0;
                        state      <= BUSY;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef INV_SUBS_FWD_EN
                        fwd_q      <= fwd;
`endif
                    end else begin
                        // First cycle after reset release raises in_ready here.
                        in_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    work <= step_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = work;

endmodule

// File: tb/tb_inv_subs_layer.sv
// Testbench for inv_subs_layer: three SIZE=64 instances (NPC=4, 1, 16) share the input side.
// When INV_SUBS_FWD_EN is defined, a SIZE=128 instance is added for the fwd path.
`timescale 1ns/1ps

module tb_inv_subs_layer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        rdy_a, ov_a, busy_a;
    logic [63:0] od_a;
    logic        rdy_b, ov_b, busy_b;
    logic [63:0] od_b;
    logic        rdy_c, ov_c, busy_c;
    logic [63:0] od_c;

    int tests = 0;
    int fails = 0;

    logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                               4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
    logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

`ifdef INV_SUBS_FWD_EN
    logic         fwd;
    logic [127:0] in_data_w;
    logic         rdy_d, ov_d, busy_d;
    logic [127:0] od_d;

    inv_subs_layer #(.SIZE(64), .NPC(4)) dut_a (
        .clk(clk), .rst(rst), .fwd(fwd), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .busy(busy_a));
    inv_subs_layer #(.SIZE(64), .NPC(1)) dut_b (
        .clk(clk), .rst(rst), .fwd(fwd), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .busy(busy_b));
    inv_subs_layer #(.SIZE(64), .NPC(16)) dut_c (
        .clk(clk), .rst(rst), .fwd(fwd), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .busy(busy_c));
    inv_subs_layer #(.SIZE(128), .NPC(4)) dut_d (
        .clk(clk), .rst(rst), .fwd(fwd), .in_valid(in_valid), .in_ready(rdy_d),
        .in_data(in_data_w), .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d), .busy(busy_d));
`else
    inv_subs_layer #(.SIZE(64), .NPC(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .busy(busy_a));
    inv_subs_layer #(.SIZE(64), .NPC(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .busy(busy_b));
    inv_subs_layer #(.SIZE(64), .NPC(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .busy(busy_c));
`endif

    // Reference: every nibble of the word maps through the chosen table, positions unchanged.
    function automatic logic [127:0] ref_sub(input logic [127:0] w, input int nibs, input bit use_fwd);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nibs; i++)
            r[4*i +: 4] = use_fwd ? fwd_t[w[4*i +: 4]] : inv_t[w[4*i +: 4]];
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present one word for a single edge; called at a negedge with dut_a idle.
    task automatic send_a(input logic [63:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until dut_a raises out_valid (bounded).
    task automatic wait_ov_a(output int lat);
        lat = 0;
        while (!ov_a && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (rdy_a !== 1'b0) begin fails++; $display("FAIL reset_in_ready_low got=%b exp=0", rdy_a); end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (rdy_a !== 1'b1 || ov_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++; $display("FAIL reset_idle_ctrl got rdy=%b ov=%b busy=%b exp 1/0/0", rdy_a, ov_a, busy_a);
        end
        tests++;
        if (od_a !== 64'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", od_a); end
        tests++;
        if (rdy_b !== 1'b1 || busy_b !== 1'b0 || rdy_c !== 1'b1 || busy_c !== 1'b0) begin
            fails++; $display("FAIL reset_other_npc got rdy_b=%b busy_b=%b rdy_c=%b busy_c=%b exp 1/0/1/0",
                              rdy_b, busy_b, rdy_c, busy_c);
        end
    endtask

    task automatic test_zero_word();
        int lat;
        out_ready = 1'b1;
        send_a(64'h0);
        wait_ov_a(lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL zero_latency got=%0d exp=4", lat); end
        tests++;
        if (od_a !== 64'h5555555555555555) begin
            fails++; $display("FAIL zero_data got=%h exp=5555555555555555", od_a);
        end
        @(negedge clk);
        tests++;
        if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin
            fails++; $display("FAIL zero_handshake got ov=%b rdy=%b exp 0/1", ov_a, rdy_a);
        end
    endtask

    task automatic test_known_word();
        int lat;
        send_a(64'h0123456789ABCDEF);
        wait_ov_a(lat);
        tests++;
        if (lat !== 4 || od_a !== 64'h5EF8C12DB463079A) begin
            fails++; $display("FAIL known_word got=%h lat=%0d exp=5EF8C12DB463079A lat=4", od_a, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        logic [63:0] w, exp_w;
        for (int k = 0; k < 8; k++) begin
            w     = rand64();
            exp_w = ref_sub({64'h0, w}, 16, 1'b0);
            send_a(w);
            wait_ov_a(lat);
            tests++;
            if (od_a !== exp_w || lat !== 4) begin
                fails++; $display("FAIL random_%0d in=%h got=%h lat=%0d exp=%h lat=4", k, w, od_a, lat, exp_w);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_npc_variants();
        int la, lb, lc;
        logic [63:0] da, db, dc;
        la = 0; lb = 0; lc = 0;
        da = '0; db = '0; dc = '0;
        do_reset();
        out_ready = 1'b1;
        send_a(64'h0123456789ABCDEF);
        for (int k = 1; k <= 40; k++) begin
            if (ov_a && la == 0) begin la = k - 1; da = od_a; end
            if (ov_b && lb == 0) begin lb = k - 1; db = od_b; end
            if (ov_c && lc == 0) begin lc = k - 1; dc = od_c; end
            @(negedge clk);
        end
        tests++;
        if (la !== 4 || da !== 64'h5EF8C12DB463079A) begin
            fails++; $display("FAIL npc4 got=%h lat=%0d exp=5EF8C12DB463079A lat=4", da, la);
        end
        tests++;
        if (lb !== 16 || db !== 64'h5EF8C12DB463079A) begin
            fails++; $display("FAIL npc1 got=%h lat=%0d exp=5EF8C12DB463079A lat=16", db, lb);
        end
        tests++;
        if (lc !== 1 || dc !== 64'h5EF8C12DB463079A) begin
            fails++; $display("FAIL npc16 got=%h lat=%0d exp=5EF8C12DB463079A lat=1", dc, lc);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [63:0] w, exp_w;
        w     = rand64();
        exp_w = ref_sub({64'h0, w}, 16, 1'b0);
        out_ready = 1'b0;
        send_a(w);
        wait_ov_a(lat);
        tests++;
        if (lat !== 4 || od_a !== exp_w) begin
            fails++; $display("FAIL hold_first got=%h lat=%0d exp=%h lat=4", od_a, lat, exp_w);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_data  = rand64();
            @(negedge clk);
            if (od_a !== exp_w || rdy_a !== 1'b0 || ov_a !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL hold_stable bad_cycles=%0d exp=0 last out=%h rdy=%b exp_out=%h", bad, od_a, rdy_a, exp_w);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (ov_a !== 1'b0 || rdy_a !== 1'b1 || busy_a !== 1'b0) begin
            fails++; $display("FAIL hold_release got ov=%b rdy=%b busy=%b exp 0/1/0", ov_a, rdy_a, busy_a);
        end
        @(negedge clk);
        tests++;
        if (busy_a !== 1'b0 || od_a !== exp_w) begin
            fails++; $display("FAIL hold_no_second got busy=%b out=%h exp busy=0 out=%h", busy_a, od_a, exp_w);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        int seen;
        out_ready = 1'b1;
        send_a(rand64());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (busy_a !== 1'b0 || ov_a !== 1'b0 || rdy_a !== 1'b0 || od_a !== 64'h0) begin
            fails++; $display("FAIL midreset_state got busy=%b ov=%b rdy=%b out=%h exp 0/0/0/0", busy_a, ov_a, rdy_a, od_a);
        end
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov_a) seen++;
        end
        tests++;
        if (seen != 0 || rdy_a !== 1'b1) begin
            fails++; $display("FAIL midreset_no_output got ov_cycles=%0d rdy=%b exp 0/1", seen, rdy_a);
        end
        send_a(64'hC56B90AD3EF84712);
        wait_ov_a(lat);
        tests++;
        if (od_a !== 64'h0123456789ABCDEF || lat !== 4) begin
            fails++; $display("FAIL midreset_next got=%h lat=%0d exp=0123456789ABCDEF lat=4", od_a, lat);
        end
        @(negedge clk);
    endtask

`ifdef INV_SUBS_FWD_EN
    task automatic test_fwd();
        int lat;
        logic [127:0] res;
        do_reset();
        tests++;
        if (rdy_d !== 1'b1 || busy_d !== 1'b0) begin
            fails++; $display("FAIL fwd_idle got rdy=%b busy=%b exp 1/0", rdy_d, busy_d);
        end
        out_ready = 1'b1;
        in_data_w = 128'h0123456789ABCDEF0123456789ABCDEF;
        fwd       = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        fwd      = 1'b0;
        lat = 0;
        while (!ov_d && lat < 100) begin @(negedge clk); lat++; end
        res = od_d;
        tests++;
        if (res !== 128'hC56B90AD3EF84712C56B90AD3EF84712 || lat !== 8) begin
            fails++; $display("FAIL fwd_encrypt got=%h lat=%0d exp=C56B90AD3EF84712C56B90AD3EF84712 lat=8", res, lat);
        end
        @(negedge clk);
        in_data_w = res;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!ov_d && lat < 100) begin @(negedge clk); lat++; end
        tests++;
        if (od_d !== 128'h0123456789ABCDEF0123456789ABCDEF || od_d !== ref_sub(res, 32, 1'b0)) begin
            fails++; $display("FAIL fwd_roundtrip got=%h exp=0123456789ABCDEF0123456789ABCDEF", od_d);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
`ifdef INV_SUBS_FWD_EN
        fwd       = 1'b0;
        in_data_w = '0;
`endif
        test_reset();
        test_zero_word();
        test_known_word();
        test_random();
        test_backpressure();
        test_reset_midflight();
        test_npc_variants();
`ifdef INV_SUBS_FWD_EN
        test_fwd();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
